alu_result_stage: RTL and testbench

Sits directly downstream of the ALU. It captures the ALU's two 32-bit result words (alu_out, alu_out2) together with the opcode into a small result buffer, and maintains the visible ZLO/ZHI registers. It delivers results to register writeback as tagged beats over a valid/ready handshake:
- Multiply (op 0100) and divide (op 0011) produce two beats: LO, then HI.
- All other valid ops produce one beat to the general destination (Z).

---
 rtl/alu_result_stage.sv | 179 +++++++++++++++++
 tb/tb_alu_result_stage.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_result_stage.sv
// Result stage behind the ALU: buffers result words, tracks ZLO/ZHI, and streams
// tagged writeback beats (one for general ops, LO then HI for multiply/divide).
module alu_result_stage #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic             clock,
    input  logic             clear,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] alu_out,
    input  logic [WIDTH-1:0] alu_out2,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       out_dest,
    output logic [WIDTH-1:0] zlo_q,
    output logic [WIDTH-1:0] zhi_q,
    output logic             busy,
    output logic             err_op
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    localparam logic [1:0] DEST_Z  = 2'b00;
    localparam logic [1:0] DEST_LO = 2'b01;
    localparam logic [1:0] DEST_HI = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        SINGLE,
        BEAT_LO,
        BEAT_HI
    } state_t;

    logic [WIDTH-1:0] lo_mem  [DEPTH];
    logic [WIDTH-1:0] hi_mem  [DEPTH];
    logic             two_mem [DEPTH];

    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    rd_ptr_inc;
    logic [PW-1:0]    load_idx;
    logic [CW-1:0]    count;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] data_nxt;
    logic [1:0]       dest_nxt;

    logic             op_ok;
    logic             op_two;
    logic             push;
    logic             bad_push;
    logic             pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign op_ok     = (op != 4'h0) && (op <= 4'hB);
    assign op_two    = (op == 4'h3) || (op == 4'h4);
    assign in_ready  = (count < CW'(DEPTH));
    assign push      = in_valid & in_ready & op_ok;
    assign bad_push  = in_valid & in_ready & ~op_ok;
    assign out_valid = (state != IDLE);
    assign busy      = (count != '0) | out_valid;

    assign rd_ptr_inc = ptr_inc(rd_ptr);
    // From IDLE the head is loaded; after a pop the entry behind it is next.
    assign load_idx   = (state == IDLE) ? rd_ptr : rd_ptr_inc;

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            wr_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                lo_mem[i]  <= '0;
                hi_mem[i]  <= '0;
                two_mem[i] <= 1'b0;
            end
        end else if (push) begin
            lo_mem[wr_ptr]  <= alu_out;
            hi_mem[wr_ptr]  <= alu_out2;
            two_mem[wr_ptr] <= op_two;
            wr_ptr          <= ptr_inc(wr_ptr);
        end
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (pop) begin
                rd_ptr <= rd_ptr_inc;
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // ZHI only tracks the upper word of multiply/divide results.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            zlo_q  <= '0;
            zhi_q  <= '0;
            err_op <= 1'b0;
        end else begin
            err_op <= bad_push;
            if (push) begin
                zlo_q <= alu_out;
                if (op_two) begin
                    zhi_q <= alu_out2;
                end
            end
        end
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state    <= IDLE;
            out_data <= '0;
            out_dest <= DEST_Z;
        end else begin
            state    <= state_nxt;
            out_data <= data_nxt;
            out_dest <= dest_nxt;
        end
    end

    // The head entry stays in the buffer until its last beat is accepted.
    always_comb begin
        state_nxt = state;
        data_nxt  = out_data;
        dest_nxt  = out_dest;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                if (count != '0) begin
                    state_nxt = two_mem[load_idx] ? BEAT_LO : SINGLE;
                    data_nxt  = lo_mem[load_idx];
                    dest_nxt  = two_mem[load_idx] ? DEST_LO : DEST_Z;
                end
            end
            SINGLE, BEAT_HI: begin
                if (out_ready) begin
                    pop = 1'b1;
                    if (count > CW'(1)) begin
                        state_nxt = two_mem[load_idx] ? BEAT_LO : SINGLE;
                        data_nxt  = lo_mem[load_idx];
                        dest_nxt  = two_mem[load_idx] ? DEST_LO : DEST_Z;
                    end else begin
                        state_nxt = IDLE;
                        data_nxt  = '0;
                        dest_nxt  = DEST_Z;
                    end
                end
            end
            BEAT_LO: begin
                if (out_ready) begin
                    state_nxt = BEAT_HI;
                    data_nxt  = hi_mem[rd_ptr];
                    dest_nxt  = DEST_HI;
                end
            end
            default: begin
                state_nxt = IDLE;
                data_nxt  = '0;
                dest_nxt  = DEST_Z;
            end
        endcase
    end

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed bench for alu_result_stage: expected beats go into a queue when pushed,
// and an independent monitor checks every delivered beat and hold stability.
module tb_alu_result_stage;

    logic        clock = 1'b0;
    logic        clear = 1'b1;
    logic [3:0]  op = 4'h0;
    logic [31:0] alu_out = '0;
    logic [31:0] alu_out2 = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic [1:0]  out_dest;
    logic [31:0] zlo_q;
    logic [31:0] zhi_q;
    logic        busy;
    logic        err_op;

    typedef struct packed {
        logic [1:0]  dest;
        logic [31:0] data;
    } beat_t;

    beat_t       exp_q[$];
    beat_t       mon_e;
    int          total = 0;
    int          bad = 0;
    logic        prev_hold = 1'b0;
    logic [31:0] prev_data = '0;
    logic [1:0]  prev_dest = '0;

    alu_result_stage #(.WIDTH(32), .DEPTH(2)) dut (
        .clock(clock), .clear(clear), .op(op), .alu_out(alu_out), .alu_out2(alu_out2),
        .in_valid(in_valid), .in_ready(in_ready), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_dest(out_dest),
        .zlo_q(zlo_q), .zhi_q(zhi_q), .busy(busy), .err_op(err_op)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drives one transfer; valid opcodes record their hand-known beats.
    task automatic applyStimulus(input logic [3:0] o, input logic [31:0] lo, input logic [31:0] hi);
        if (o == 4'h3 || o == 4'h4) begin
            exp_q.push_back('{dest: 2'b01, data: lo});
            exp_q.push_back('{dest: 2'b10, data: hi});
        end else if (o >= 4'h1 && o <= 4'hB) begin
            exp_q.push_back('{dest: 2'b00, data: lo});
        end
        in_valid = 1'b1;
        op       = o;
        alu_out  = lo;
        alu_out2 = hi;
        @(posedge clock); #1;
        in_valid = 1'b0;
        op       = 4'h0;
        alu_out  = '0;
        alu_out2 = '0;
    endtask

    task automatic waitIdle(input string name);
        for (int i = 0; i < 100; i++) begin
            if (!busy) break;
            @(posedge clock); #1;
        end
        check({name, "_busy"}, busy, 0);
        check({name, "_drained"}, exp_q.size(), 0);
    endtask

    always @(negedge clock) begin
        if (clear) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                check("hold_valid", out_valid, 1);
                check("hold_beat", {out_dest, out_data}, {prev_dest, prev_data});
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL unexpected_beat: got dest=%b data=%h expected none", out_dest, out_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("beat", {out_dest, out_data}, {mon_e.dest, mon_e.data});
                end
            end
            prev_hold = out_valid && !out_ready;
            prev_data = out_data;
            prev_dest = out_dest;
        end
    end

    initial begin
        repeat (2) @(posedge clock);
        #1 clear = 1'b0;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_dest", out_dest, 0);
        check("rst_zlo", zlo_q, 0);
        check("rst_zhi", zhi_q, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err_op, 0);
        check("rst_in_ready", in_ready, 1);

        // single-beat add
        out_ready = 1'b1;
        applyStimulus(4'h1, 32'h0000_000C, 32'h0000_0055);
        check("add_zlo", zlo_q, 32'h0000_000C);
        check("add_zhi_hold", zhi_q, 0);
        check("add_busy", busy, 1);
        waitIdle("add");

        // multiply -3 x 4
        applyStimulus(4'h4, 32'hFFFF_FFF4, 32'hFFFF_FFFF);
        check("mul_zlo", zlo_q, 32'hFFFF_FFF4);
        check("mul_zhi", zhi_q, 32'hFFFF_FFFF);
        waitIdle("mul");

        // divide 17/5 under backpressure
        out_ready = 1'b0;
        applyStimulus(4'h3, 32'd3, 32'd2);
        repeat (3) @(posedge clock);
        #1;
        check("div_bp_valid", out_valid, 1);
        check("div_bp_dest", out_dest, 2'b01);
        check("div_bp_data", out_data, 32'd3);
        check("div_zhi", zhi_q, 32'd2);
        out_ready = 1'b1;
        waitIdle("div");

        // full buffer
        out_ready = 1'b0;
        applyStimulus(4'h5, 32'hA, 32'h0);
        applyStimulus(4'h6, 32'hB, 32'h0);
        check("full_in_ready", in_ready, 0);
        in_valid = 1'b1;
        op       = 4'h7;
        alu_out  = 32'hC;
        repeat (2) @(posedge clock);
        #1;
        in_valid = 1'b0;
        op       = 4'h0;
        alu_out  = '0;
        check("full_no_accept_zlo", zlo_q, 32'hB);
        check("full_zhi_hold", zhi_q, 32'd2);
        out_ready = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        check("full_back_to_back", busy, 0);
        waitIdle("full");

        // invalid opcodes and the highest valid opcode
        applyStimulus(4'h0, 32'h1234, 32'h5678);
        check("inv0_err", err_op, 1);
        check("inv0_busy", busy, 0);
        check("inv0_zlo", zlo_q, 32'hB);
        @(posedge clock); #1;
        check("inv0_err_clear", err_op, 0);
        applyStimulus(4'hC, 32'h4321, 32'h8765);
        check("invC_err", err_op, 1);
        check("invC_zhi", zhi_q, 32'd2);
        applyStimulus(4'hB, 32'h77, 32'h88);
        check("opB_err", err_op, 0);
        check("opB_zlo", zlo_q, 32'h77);
        waitIdle("opB");
        check("opB_zhi_hold", zhi_q, 32'd2);

        // reset while in the HI beat with another entry queued
        out_ready = 1'b0;
        applyStimulus(4'h4, 32'h11, 32'h22);
        applyStimulus(4'h1, 32'h33, 32'h0);
        out_ready = 1'b1;
        @(posedge clock); #1;
        out_ready = 1'b0;
        check("mid_dest_hi", out_dest, 2'b10);
        check("mid_data_hi", out_data, 32'h22);
        check("mid_pending", exp_q.size(), 2);
        clear = 1'b1;
        #1;
        check("clr_out_valid", out_valid, 0);
        check("clr_out_data", out_data, 0);
        check("clr_out_dest", out_dest, 0);
        check("clr_zlo", zlo_q, 0);
        check("clr_busy", busy, 0);
        check("clr_err", err_op, 0);
        exp_q.delete();
        @(posedge clock); #1;
        clear     = 1'b0;
        out_ready = 1'b1;
        repeat (10) @(posedge clock);
        #1;
        check("post_clr_valid", out_valid, 0);
        check("post_clr_busy", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
